// File: rtl/data_pack_pkg.sv
// data_pack_pkg: shared defaults, derived widths and FSM state type for the data_pack slice.
//   SYM_W_DEF / WORD_W_DEF : default symbol / packed word widths
//   ACC_W                  : accumulator width, enough for a partial word plus one symbol
//   CNT_W                  : fill-count width, able to hold 0..ACC_W
//   EMPTY_W                : width of the optional empty-bit count (DATA_PACK_EMPTY_EN)
package data_pack_pkg;

  localparam int unsigned SYM_W_DEF  = 7;
  localparam int unsigned WORD_W_DEF = 32;
  localparam int unsigned ACC_W      = WORD_W_DEF + SYM_W_DEF - 1;
  localparam int unsigned CNT_W      = $clog2(ACC_W + 1);
  localparam int unsigned EMPTY_W    = $clog2(WORD_W_DEF);

  typedef enum logic [1:0] {
    StIdle,
    StPack,
    StFlush
  } state_e;

endpackage

// File: rtl/data_pack_oreg.sv
// data_pack_oreg: output holding register for the packed word stream.
// Loads a new word only when the slot is free and holds it stable while the
// downstream stalls.
// Optional: `DATA_PACK_EMPTY_EN adds the empty-bit count alongside the word.
// Ports:
//   clk, rst        : clock, asynchronous active-low reset
//   i_load          : load i_data/i_sop/i_eop(/i_empty) this cycle (only when o_free)
//   i_ready         : downstream accepts the current word
//   o_data/o_valid/o_sop/o_eop(/o_empty) : registered word interface
//   o_free          : slot is empty or being drained this cycle
module data_pack_oreg
  import data_pack_pkg::*;
#(
  parameter int unsigned WORD_W = WORD_W_DEF
`ifdef DATA_PACK_EMPTY_EN
  ,
  parameter int unsigned EMPTY_W_P = $clog2(WORD_W)
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_load,
  input  logic [WORD_W-1:0] i_data,
  input  logic              i_sop,
  input  logic              i_eop,
`ifdef DATA_PACK_EMPTY_EN
  input  logic [EMPTY_W_P-1:0] i_empty,
  output logic [EMPTY_W_P-1:0] o_empty,
`endif
  input  logic              i_ready,
  output logic [WORD_W-1:0] o_data,
  output logic              o_valid,
  output logic              o_sop,
  output logic              o_eop,
  output logic              o_free
);

  logic [WORD_W-1:0] r_data;
  logic              r_valid;
  logic              r_sop;
  logic              r_eop;
`ifdef DATA_PACK_EMPTY_EN
  logic [EMPTY_W_P-1:0] r_empty;
`endif

  assign o_free = !r_valid || i_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_data  <= '0;
      r_valid <= 1'b0;
      r_sop   <= 1'b0;
      r_eop   <= 1'b0;
`ifdef DATA_PACK_EMPTY_EN
      r_empty <= '0;
`endif
    end else if (i_load) begin
      r_data  <= i_data;
      r_valid <= 1'b1;
      r_sop   <= i_sop;
      r_eop   <= i_eop;
`ifdef DATA_PACK_EMPTY_EN
      r_empty <= i_empty;
`endif
    end else if (i_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign o_data  = r_data;
  assign o_valid = r_valid;
  assign o_sop   = r_sop;
  assign o_eop   = r_eop;
`ifdef DATA_PACK_EMPTY_EN
  assign o_empty = r_empty;
`endif

endmodule

// File: rtl/data_pack.sv
// data_pack: packs a packetised stream of SYM_W-bit symbols contiguously, LSB-first,
// into WORD_W-bit words. Symbols may straddle word boundaries; the last word of a
// packet is zero-padded and flagged with eop_out.
// Optional: `DATA_PACK_EMPTY_EN adds empty_out (unused upper bits on eop words).
// Ports:
//   clk, rst                          : clock, asynchronous active-low reset
//   data_in/valid_in/sop_in/eop_in    : symbol stream in
//   ready_out                         : symbol accepted when valid_in && ready_out
//   data_out/valid_out/sop_out/eop_out: packed word stream out
//   ready_in                          : word transferred when valid_out && ready_in
module data_pack
  import data_pack_pkg::*;
#(
  parameter int unsigned SYM_W  = SYM_W_DEF,
  parameter int unsigned WORD_W = WORD_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [SYM_W-1:0]  data_in,
  input  logic              valid_in,
  input  logic              sop_in,
  input  logic              eop_in,
  output logic              ready_out,
  output logic [WORD_W-1:0] data_out,
  output logic              valid_out,
  output logic              sop_out,
  output logic              eop_out,
`ifdef DATA_PACK_EMPTY_EN
  output logic [$clog2(WORD_W)-1:0] empty_out,
`endif
  input  logic              ready_in
);

  localparam int unsigned AccW = WORD_W + SYM_W - 1;
  localparam int unsigned CntW = $clog2(AccW + 1);
  localparam logic [CntW-1:0] WordCnt = CntW'(WORD_W);
  localparam logic [CntW-1:0] SymCnt  = CntW'(SYM_W);
`ifdef DATA_PACK_EMPTY_EN
  localparam int unsigned EmptyW = $clog2(WORD_W);
`endif

  state_e            r_state;
  logic [AccW-1:0]   r_acc;
  logic [CntW-1:0]   r_cnt;
  logic              r_sop_pend;

  state_e            w_state_d;
  logic [AccW-1:0]   w_acc_d;
  logic [CntW-1:0]   w_cnt_d;
  logic              w_sop_pend_d;

  logic              w_free;
  logic              w_accept;
  logic              w_in_pkt;
  logic              w_restart;
  logic              w_pend_eff;
  logic [AccW-1:0]   w_base_acc;
  logic [CntW-1:0]   w_base_cnt;
  logic [AccW-1:0]   w_acc_new;
  logic [CntW-1:0]   w_n;

  logic              w_load;
  logic [WORD_W-1:0] w_ld_data;
  logic              w_ld_sop;
  logic              w_ld_eop;
`ifdef DATA_PACK_EMPTY_EN
  logic [EmptyW-1:0] w_ld_empty;
`endif

  // Held low through reset even though the output slot reads as free.
  assign ready_out = rst && w_free && (r_state != StFlush);
  assign w_accept  = valid_in && ready_out;

  // A symbol with sop_in always opens a fresh packet, discarding any partial word.
  assign w_restart  = sop_in;
  assign w_in_pkt   = w_restart || (r_state == StPack);
  assign w_pend_eff = w_restart || r_sop_pend;
  assign w_base_acc = (r_state == StPack && !w_restart) ? r_acc : '0;
  assign w_base_cnt = (r_state == StPack && !w_restart) ? r_cnt : '0;
  assign w_acc_new  = w_base_acc | (AccW'(data_in) << w_base_cnt);
  assign w_n        = w_base_cnt + SymCnt;

  always_comb begin
    w_state_d    = r_state;
    w_acc_d      = r_acc;
    w_cnt_d      = r_cnt;
    w_sop_pend_d = r_sop_pend;
    w_load       = 1'b0;
    w_ld_data    = w_acc_new[WORD_W-1:0];
    w_ld_sop     = w_pend_eff;
    w_ld_eop     = 1'b0;
`ifdef DATA_PACK_EMPTY_EN
    w_ld_empty   = '0;
`endif

    if (r_state == StFlush) begin
      if (w_free) begin
        w_load       = 1'b1;
        w_ld_data    = r_acc[WORD_W-1:0];
        w_ld_sop     = r_sop_pend;
        w_ld_eop     = 1'b1;
`ifdef DATA_PACK_EMPTY_EN
        w_ld_empty   = EmptyW'(WordCnt - r_cnt);
`endif
        w_acc_d      = '0;
        w_cnt_d      = '0;
        w_sop_pend_d = 1'b0;
        w_state_d    = StIdle;
      end
    end else if (w_accept && w_in_pkt) begin
      if (eop_in && (w_n <= WordCnt)) begin
        // Whole packet tail fits in this word.
        w_load       = 1'b1;
        w_ld_eop     = 1'b1;
`ifdef DATA_PACK_EMPTY_EN
        w_ld_empty   = EmptyW'(WordCnt - w_n);
`endif
        w_acc_d      = '0;
        w_cnt_d      = '0;
        w_sop_pend_d = 1'b0;
        w_state_d    = StIdle;
      end else if (w_n >= WordCnt) begin
        // Word full; the spill-over stays in the accumulator. With eop the
        // spill-over still needs its own word, so block input for one slot.
        w_load       = 1'b1;
        w_acc_d      = w_acc_new >> WORD_W;
        w_cnt_d      = w_n - WordCnt;
        w_sop_pend_d = 1'b0;
        w_state_d    = eop_in ? StFlush : StPack;
      end else begin
        w_acc_d      = w_acc_new;
        w_cnt_d      = w_n;
        w_sop_pend_d = w_pend_eff;
        w_state_d    = StPack;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= StIdle;
      r_acc      <= '0;
      r_cnt      <= '0;
      r_sop_pend <= 1'b0;
    end else begin
      r_state    <= w_state_d;
      r_acc      <= w_acc_d;
      r_cnt      <= w_cnt_d;
      r_sop_pend <= w_sop_pend_d;
    end
  end

  data_pack_oreg #(
    .WORD_W (WORD_W)
  ) u_oreg (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_load),
    .i_data  (w_ld_data),
    .i_sop   (w_ld_sop),
    .i_eop   (w_ld_eop),
`ifdef DATA_PACK_EMPTY_EN
    .i_empty (w_ld_empty),
    .o_empty (empty_out),
`endif
    .i_ready (ready_in),
    .o_data  (data_out),
    .o_valid (valid_out),
    .o_sop   (sop_out),
    .o_eop   (eop_out),
    .o_free  (w_free)
  );

endmodule

// File: tb/tb_data_pack.sv
// tb_data_pack: scoreboard bench for data_pack. Stimulus pushes expected words into a
// queue; a negedge monitor pops and compares every transferred word.
module tb_data_pack;

  typedef struct packed {
    logic [31:0] data;
    logic        sop;
    logic        eop;
    logic [4:0]  empty;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [6:0]  data_in;
  logic        valid_in;
  logic        sop_in;
  logic        eop_in;
  logic        ready_out;
  logic [31:0] data_out;
  logic        valid_out;
  logic        sop_out;
  logic        eop_out;
  logic        ready_in;
`ifdef DATA_PACK_EMPTY_EN
  logic [4:0]  empty_out;
`endif

  exp_t        exp_q[$];
  int          errors = 0;
  int          checks = 0;
  int          notready_cnt = 0;
  int          words_seen = 0;
  logic        prev_hold = 1'b0;
  logic [31:0] prev_data;
  logic        prev_sop;
  logic        prev_eop;

  always #5 clk = ~clk;

  data_pack u_dut (
    .clk       (clk),
    .rst       (rst),
    .data_in   (data_in),
    .valid_in  (valid_in),
    .sop_in    (sop_in),
    .eop_in    (eop_in),
    .ready_out (ready_out),
    .data_out  (data_out),
    .valid_out (valid_out),
    .sop_out   (sop_out),
    .eop_out   (eop_out),
`ifdef DATA_PACK_EMPTY_EN
    .empty_out (empty_out),
`endif
    .ready_in  (ready_in)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, req);
    end
  endtask

  task automatic push_exp(input logic [31:0] d, input logic s, input logic e,
                          input logic [4:0] em);
    exp_t x;
    x.data  = d;
    x.sop   = s;
    x.eop   = e;
    x.empty = em;
    exp_q.push_back(x);
  endtask

  // Bit-serial reference: lay symbols out on a flat bit line, then cut into words.
  task automatic model_push(input logic [6:0] s[$]);
    int   nb;
    int   nw;
    int   idx;
    exp_t x;
    logic [6:0] t;
    nb = s.size() * 7;
    nw = (nb + 31) / 32;
    for (int w = 0; w < nw; w++) begin
      x = '0;
      for (int b = 0; b < 32; b++) begin
        idx = w * 32 + b;
        if (idx < nb) begin
          t = s[idx / 7];
          x.data[b] = t[idx % 7];
        end
      end
      x.sop   = (w == 0);
      x.eop   = (w == nw - 1);
      x.empty = x.eop ? 5'(nw * 32 - nb) : 5'd0;
      exp_q.push_back(x);
    end
  endtask

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send_sym(input logic [6:0] d, input logic s, input logic e);
    bit got;
    got      = 1'b0;
    data_in  = d;
    sop_in   = s;
    eop_in   = e;
    valid_in = 1'b1;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (ready_out) begin
        got = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: got ready_out=0 for 200 cycles, required 1");
    end else begin
      @(posedge clk);
      #1;
    end
    valid_in = 1'b0;
    sop_in   = 1'b0;
    eop_in   = 1'b0;
  endtask

  task automatic send_pkt(input logic [6:0] s[$]);
    for (int i = 0; i < s.size(); i++) begin
      send_sym(s[i], i == 0, i == s.size() - 1);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor: scoreboard compare on every transfer, plus hold checks under stall.
  always @(negedge clk) begin
    if (rst) begin
      if (!ready_out) notready_cnt++;
      if (prev_hold) begin
        check("hold_valid", 32'(valid_out), 32'd1);
        check("hold_data", data_out, prev_data);
        check("hold_sop", 32'(sop_out), 32'(prev_sop));
        check("hold_eop", 32'(eop_out), 32'(prev_eop));
      end
      if (valid_out && ready_in) begin
        words_seen++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_word: got 0x%08h, required no word", data_out);
        end else begin
          exp_t x;
          x = exp_q.pop_front();
          check("word_data", data_out, x.data);
          check("word_sop", 32'(sop_out), 32'(x.sop));
          check("word_eop", 32'(eop_out), 32'(x.eop));
`ifdef DATA_PACK_EMPTY_EN
          check("word_empty", 32'(empty_out), 32'(x.empty));
`endif
        end
      end
      prev_hold = valid_out && !ready_in;
      prev_data = data_out;
      prev_sop  = sop_out;
      prev_eop  = eop_out;
    end else begin
      prev_hold = 1'b0;
    end
  end

  initial begin
    logic [6:0] q[$];
    int         w0;

    rst      = 1'b0;
    data_in  = '0;
    valid_in = 1'b0;
    sop_in   = 1'b0;
    eop_in   = 1'b0;
    ready_in = 1'b1;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_data", data_out, 32'd0);
    check("rst_valid", 32'(valid_out), 32'd0);
    check("rst_sop", 32'(sop_out), 32'd0);
    check("rst_eop", 32'(eop_out), 32'd0);
    check("rst_ready_out", 32'(ready_out), 32'd0);
`ifdef DATA_PACK_EMPTY_EN
    check("rst_empty", 32'(empty_out), 32'd0);
`endif
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check("ready_after_rst", 32'(ready_out), 32'd1);
    @(posedge clk);
    #1;

    // 1..5: spills into a FLUSH word
    notready_cnt = 0;
    push_exp(32'h5080C101, 1'b1, 1'b0, 5'd0);
    push_exp(32'h00000000, 1'b0, 1'b1, 5'd29);
    q.delete();
    for (int i = 1; i <= 5; i++) q.push_back(7'(i));
    send_pkt(q);
    idle(5);
    check("t1_flush_notready_cycles", 32'(notready_cnt), 32'd1);

    // All-ones symbols
    push_exp(32'hFFFFFFFF, 1'b1, 1'b0, 5'd0);
    push_exp(32'h00000007, 1'b0, 1'b1, 5'd29);
    q.delete();
    repeat (5) q.push_back(7'h7F);
    send_pkt(q);
    idle(5);

    // 32 symbols: exactly 7 words, no flush, no ready drop
    notready_cnt = 0;
    w0 = words_seen;
    q.delete();
    for (int i = 0; i < 32; i++) q.push_back(7'(i));
    model_push(q);
    send_pkt(q);
    idle(5);
    check("t3_notready_cycles", 32'(notready_cnt), 32'd0);
    check("t3_word_count", 32'(words_seen - w0), 32'd7);

    // Single-symbol packet
    push_exp(32'h0000002A, 1'b1, 1'b1, 5'd25);
    send_sym(7'h2A, 1'b1, 1'b1);
    idle(3);

    // Stray symbol dropped; sop mid-packet restarts
    push_exp(32'h00000203, 1'b1, 1'b1, 5'd18);
    send_sym(7'h55, 1'b0, 1'b0);
    send_sym(7'h01, 1'b1, 1'b0);
    send_sym(7'h02, 1'b0, 1'b0);
    send_sym(7'h03, 1'b1, 1'b0);
    send_sym(7'h04, 1'b0, 1'b1);
    idle(3);

    // Downstream stall mid-packet
    q.delete();
    for (int i = 0; i < 10; i++) q.push_back(7'(8'h11 + i));
    model_push(q);
    fork
      send_pkt(q);
      begin
        repeat (3) @(posedge clk);
        #1 ready_in = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        check("stall_ready_out", 32'(ready_out), 32'd0);
        check("stall_valid_out", 32'(valid_out), 32'd1);
        @(posedge clk);
        #1 ready_in = 1'b1;
      end
    join
    idle(5);

    // Reset mid-packet, then a fresh packet
    send_sym(7'h10, 1'b1, 1'b0);
    send_sym(7'h20, 1'b0, 1'b0);
    send_sym(7'h30, 1'b0, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    check("midrst_data", data_out, 32'd0);
    check("midrst_valid", 32'(valid_out), 32'd0);
    check("midrst_ready_out", 32'(ready_out), 32'd0);
    @(posedge clk);
    #1 rst = 1'b1;
    push_exp(32'h0890E141, 1'b1, 1'b1, 5'd4);
    q.delete();
    for (int i = 0; i < 4; i++) q.push_back(7'(8'h41 + i));
    send_pkt(q);

    // Drain
    for (int t = 0; t < 100; t++) begin
      if (exp_q.size() == 0) break;
      @(posedge clk);
    end
    idle(3);
    check("words_outstanding", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
